// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 LCD write path.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_DDRAM_L1     = 8'h80;

    typedef enum logic [2:0] {POWERUP, INIT, IDLE, ADDR, CHARS} top_state_t;
    typedef enum logic [1:0] {SETUP, EHIGH, HOLD, WAIT} byte_phase_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Power-up command list, sent in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        c = LCD_FUNC_8BIT_2L;
        case (idx)
            2'd0: c = LCD_FUNC_8BIT_2L;
            2'd1: c = LCD_DISP_ON;
            2'd2: c = LCD_ENTRY_INC;
            2'd3: c = LCD_CLEAR;
            default: c = LCD_FUNC_8BIT_2L;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_byte_writer.sv
// Single-byte panel write: setup, E pulse, hold, then the command execution wait.
// A new start is accepted while idle or in the last WAIT cycle, so bytes chain
// with no dead cycle between one WAIT and the next SETUP.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 3,
    parameter int T_PULSE = 12,
    parameter int T_HOLD  = 3,
    parameter int CW      = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    byte_in,
    input  logic          rs_in,
    input  logic [CW-1:0] wait_cycles,
    output logic          busy,
    output logic          done,
    output logic          lcd_e,
    output logic          lcd_rs,
    output logic [7:0]    lcd_d
);

    byte_phase_t   phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          busy_q, busy_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    d_q, d_d;

    assign done   = busy_q && (phase_q == WAIT) && (cnt_q == '0);
    assign busy   = busy_q;
    assign lcd_e  = e_q;
    assign lcd_rs = rs_q;
    assign lcd_d  = d_q;

    // Phase sequencing: each phase loads T-1 and runs down to zero.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        e_d     = e_q;
        rs_d    = rs_q;
        d_d     = d_q;
        if (start && (!busy_q || done)) begin
            busy_d  = 1'b1;
            phase_d = SETUP;
            cnt_d   = CW'(T_SETUP - 1);
            wait_d  = wait_cycles;
            d_d     = byte_in;
            rs_d    = rs_in;
        end else if (busy_q) begin
            unique case (phase_q)
                SETUP: begin
                    if (cnt_q == '0) begin
                        phase_d = EHIGH;
                        e_d     = 1'b1;
                        cnt_d   = CW'(T_PULSE - 1);
                    end else cnt_d = cnt_q - CW'(1);
                end
                EHIGH: begin
                    if (cnt_q == '0) begin
                        phase_d = HOLD;
                        e_d     = 1'b0;
                        cnt_d   = CW'(T_HOLD - 1);
                    end else cnt_d = cnt_q - CW'(1);
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        phase_d = WAIT;
                        cnt_d   = wait_q - CW'(1);
                    end else cnt_d = cnt_q - CW'(1);
                end
                WAIT: begin
                    if (cnt_q == '0) busy_d = 1'b0;
                    else             cnt_d  = cnt_q - CW'(1);
                end
            endcase
        end
    end

    // State and panel-output registers; reset drops E at once, even mid-pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= SETUP;
            cnt_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            d_q     <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
        end
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only controller: power-up delay, init commands, then
// per-request DDRAM address plus four characters on line 1.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int Width     = 32,
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 3,
    parameter int T_PULSE   = 12,
    parameter int T_HOLD    = 3,
    parameter int T_EXEC    = 2500,
    parameter int T_CLEAR   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             init_done,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic             lcd_e,
    output logic [7:0]       lcd_d
);

    localparam int TMAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                               max2(T_EXEC, T_CLEAR));
    localparam int CW   = $clog2(TMAX) + 1;

    top_state_t       state_q, state_d;
    logic [CW-1:0]    pu_cnt_q, pu_cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [1:0]       char_idx_q, char_idx_d;
    logic [1:0]       char_nxt;
    logic [Width-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;

    logic             wr_start, wr_rs, wr_busy, wr_done;
    logic [7:0]       wr_byte;
    logic [CW-1:0]    wr_wait;

    assign char_nxt  = char_idx_q + 2'd1;
    // Only the Clear command needs the long execution wait.
    assign wr_wait   = (wr_byte == LCD_CLEAR && !wr_rs) ? CW'(T_CLEAR) : CW'(T_EXEC);
    assign ready     = ready_q;
    assign init_done = init_done_q;
    assign lcd_rw    = 1'b0;

    // Top sequencing; on the writer's done cycle the next byte is issued
    // directly so it chains without a gap.
    always_comb begin
        state_d     = state_q;
        pu_cnt_d    = pu_cnt_q;
        init_idx_d  = init_idx_q;
        char_idx_d  = char_idx_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        wr_start    = 1'b0;
        wr_byte     = 8'h00;
        wr_rs       = 1'b0;
        unique case (state_q)
            POWERUP: begin
                if (pu_cnt_q == '0) begin
                    state_d    = INIT;
                    init_idx_d = 2'd0;
                end else pu_cnt_d = pu_cnt_q - CW'(1);
            end
            INIT: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_byte  = init_cmd(init_idx_q);
                end else if (wr_done) begin
                    if (init_idx_q == 2'd3) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        wr_start   = 1'b1;
                        wr_byte    = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end
            IDLE: begin
                if (valid && ready_q) begin
                    data_d  = data;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!wr_busy) begin
                    wr_start = 1'b1;
                    wr_byte  = LCD_DDRAM_L1;
                end else if (wr_done) begin
                    state_d    = CHARS;
                    char_idx_d = 2'd0;
                    wr_start   = 1'b1;
                    wr_byte    = data_q[7:0];
                    wr_rs      = 1'b1;
                end
            end
            CHARS: begin
                if (wr_done) begin
                    if (char_idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        char_idx_d = char_nxt;
                        wr_start   = 1'b1;
                        wr_byte    = data_q[{char_nxt, 3'b000} +: 8];
                        wr_rs      = 1'b1;
                    end
                end
            end
            default: state_d = POWERUP;
        endcase
        ready_d = (state_d == IDLE);
    end

    // Top state registers; reset discards any captured word and replays init.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= POWERUP;
            pu_cnt_q    <= CW'(T_POWERUP - 1);
            init_idx_q  <= 2'd0;
            char_idx_q  <= 2'd0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pu_cnt_q    <= pu_cnt_d;
            init_idx_q  <= init_idx_d;
            char_idx_q  <= char_idx_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_byte_writer #(
        .T_SETUP(T_SETUP),
        .T_PULSE(T_PULSE),
        .T_HOLD (T_HOLD),
        .CW     (CW)
    ) u_writer (
        .clk        (clk),
        .rst        (reset),
        .start      (wr_start),
        .byte_in    (wr_byte),
        .rs_in      (wr_rs),
        .wait_cycles(wr_wait),
        .busy       (wr_busy),
        .done       (wr_done),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_d      (lcd_d)
    );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: stimulus pushes expected E-pulse bytes, a monitor pops on each E rise.
module tb_lcd_hd44780_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        valid;
    logic        ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_d;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl #(
        .Width(32), .T_POWERUP(20), .T_SETUP(2), .T_PULSE(4),
        .T_HOLD(2), .T_EXEC(8), .T_CLEAR(30)
    ) dut (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
        .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    typedef struct packed { logic rs; logic [7:0] d; } pulse_t;
    pulse_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        checks++;
        if (act < min) begin
            failures++;
            $display("FAIL %s: got %0d expected >= %0d", name, act, min);
        end
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        pulse_t p;
        p.rs = rs;
        p.d  = d;
        exp_q.push_back(p);
    endtask

    task automatic push_xfer(input logic [31:0] w);
        push(1'b0, 8'h80);
        for (int i = 0; i < 4; i++) push(1'b1, w[8*i +: 8]);
    endtask

    // ---------------- monitor ----------------
    int cyc = 0, npulses = 0, first_rise = 0, last_rise = 0, last_fall = 0;
    int hi_len = 0, post = 0, stab_err = 0;
    logic       prev_e = 1'b0;
    logic [8:0] h1 = '0, h2 = '0, pv = '0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            cyc = 0; npulses = 0; prev_e = 1'b0; post = 0; stab_err = 0;
            hi_len = 0; h1 = '0; h2 = '0;
        end else begin
            cyc++;
            if (lcd_e && !prev_e) begin
                npulses++;
                if (npulses == 1) first_rise = cyc;
                last_rise = cyc;
                hi_len = 1;
                pv = {lcd_rs, lcd_d};
                chk("setup_stable_m2", h2, pv);
                chk("setup_stable_m1", h1, pv);
                chk("rw_low", lcd_rw, 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", {lcd_rs, lcd_d}, 9'h1ff);
                    chk("spurious_pulse_cnt", 0, 1);
                end else begin
                    pulse_t e;
                    e = exp_q.pop_front();
                    chk("pulse_rs_d", {lcd_rs, lcd_d}, e);
                end
            end else if (lcd_e) begin
                hi_len++;
                if ({lcd_rs, lcd_d} !== pv) stab_err++;
            end else if (prev_e) begin
                chk("e_width", hi_len, 4);
                if ({lcd_rs, lcd_d} !== pv) stab_err++;
                last_fall = cyc;
                post = 2;
            end else if (post > 0) begin
                if ({lcd_rs, lcd_d} !== pv) stab_err++;
                post--;
                if (post == 0) begin
                    chk("dr_stable", stab_err, 0);
                    stab_err = 0;
                end
            end
            h2 = h1;
            h1 = {lcd_rs, lcd_d};
            prev_e = lcd_e;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string nm, input int maxc);
        int n = 0;
        while (ready !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
        chk(nm, ready, 1);
    endtask

    task automatic wait_pulses(input string nm, input int target, input int maxc);
        int n = 0;
        while (npulses < target && n < maxc) begin @(negedge clk); n++; end
        chk_ge(nm, npulses, target);
    endtask

    task automatic run_init(input string tag);
        int n = 0;
        while (init_done !== 1'b1 && n < 800) begin @(negedge clk); n++; end
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_npulses"}, npulses, 4);
        chk_ge({tag, "_powerup_quiet"}, first_rise, 21);
        chk_ge({tag, "_clear_gap"}, cyc - last_fall, 32);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h06); push(1'b0, 8'h01);
    endtask

    initial begin
        int acc, acc1, acc2, base;
        reset = 1'b1; valid = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_d", lcd_d, 8'h00);

        // 1: init sequence
        push_init();
        reset = 1'b0;
        run_init("t1");

        // 2/3: one transfer, with an ignored request while busy
        base = npulses;
        data = 32'h44434241; valid = 1'b1; push_xfer(32'h44434241);
        @(negedge clk);
        valid = 1'b0; acc = cyc;
        chk("t2_ready_drop", ready, 0);
        wait_pulses("t2_first_pulse", base + 1, 50);
        chk("t2_e_latency", last_rise - acc, 3);
        repeat (10) @(negedge clk);
        data = 32'hFFFFFFFF; valid = 1'b1;
        chk("t3_ready_busy", ready, 0);
        @(negedge clk);
        valid = 1'b0;
        wait_ready("t2_ready_back", 300);
        chk("t2_xfer_len", cyc - acc, 81);
        chk("t2_pulses", npulses - base, 5);
        chk("t2_queue_empty", exp_q.size(), 0);
        repeat (30) @(negedge clk);
        chk("t3_no_extra", npulses - base, 5);

        // 5: reset during the second character's E pulse
        base = npulses;
        data = 32'h64636261; valid = 1'b1; push_xfer(32'h64636261);
        @(negedge clk);
        valid = 1'b0;
        wait_pulses("t5_reach_char1", base + 3, 200);
        chk("t5_e_high", lcd_e, 1);
        reset = 1'b1;
        #1;
        chk("t5_e_async", lcd_e, 0);
        chk("t5_ready_async", ready, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_init();
        reset = 1'b0;
        run_init("t5");
        repeat (40) @(negedge clk);
        chk("t5_no_stale", npulses, 4);

        // 6: back-to-back with valid held high
        base = npulses;
        data = 32'h34333231; valid = 1'b1;
        push_xfer(32'h34333231); push_xfer(32'h34333231);
        @(negedge clk);
        acc1 = cyc;
        chk("t6_ready_drop1", ready, 0);
        wait_ready("t6_ready_mid", 300);
        chk("t6_len1", cyc - acc1, 81);
        @(negedge clk);
        acc2 = cyc;
        valid = 1'b0;
        chk("t6_single_idle", ready, 0);
        chk("t6_accept_gap", acc2 - acc1, 82);
        wait_ready("t6_ready_end", 300);
        chk("t6_pulses", npulses - base, 10);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
